// File: rtl/rice_pkg.sv
// Shared constants, state encoding and FS limit helper for the Rice block decoder.
package rice_pkg;

  localparam int N     = 10;
  localparam int J     = 32;
  localparam int ID_W  = 4;
  localparam int K_MAX = 8;
  localparam logic [ID_W-1:0] ID_RAW = 4'hF;

  typedef enum logic [2:0] {
    S_ID,
    S_REF,
    S_FS,
    S_SPLIT,
    S_RAW,
    S_OUT
  } state_t;

  // Largest legal fundamental-sequence value for split option k.
  function automatic logic [N-1:0] fs_limit(input logic [ID_W-1:0] k);
    return {N{1'b1}} >> k;
  endfunction

endpackage

// File: rtl/rice_fs_counter.sv
// Zero-run counter for one fundamental sequence: counts zeros, reports the
// terminating '1' (done) or a run that exceeds the limit (overflow).
module rice_fs_counter
  import rice_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         bit_valid,
  input  logic         bit_in,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         done,
  output logic         overflow
);

  assign done     = bit_valid && bit_in;
  assign overflow = bit_valid && !bit_in && (count == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear || done || overflow)
      count <= '0;
    else if (bit_valid)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/rice_block_decoder.sv
// Bit-serial Rice split-sample block decoder (32 x 10-bit samples per block).
// Define RICE_REF_SAMPLE_EN to parse a 10-bit reference sample after each ID.
module rice_block_decoder
  import rice_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_bit,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [N*J-1:0] symbol,
  output logic [N-1:0]   xref,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           block_err
);

  localparam logic [4:0] LAST_IDX = 5'(J - 1);

  state_t          state, state_nx;
  logic            accept, enter, err_nx;
  logic [3:0]      bit_cnt;
  logic [4:0]      idx;
  logic [3:0]      id_r, id_full, k_last;
  logic            id_legal;
  logic [N-1:0]    fs_mem [J];
  logic [N-1:0]    fs_count;
  logic            fs_done, fs_ovf;

  function automatic state_t payload_state(input logic [3:0] id);
    return (id == ID_RAW) ? S_RAW : S_FS;
  endfunction

  assign accept   = in_valid && in_ready;
  assign id_full  = {id_r[2:0], in_bit};
  assign id_legal = (id_full == ID_RAW) || (id_full <= 4'(K_MAX));
  assign k_last   = id_r - 4'd1;

  rice_fs_counter u_fs_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (state != S_FS),
    .bit_valid (accept && (state == S_FS)),
    .bit_in    (in_bit),
    .limit     (fs_limit(id_r)),
    .count     (fs_count),
    .done      (fs_done),
    .overflow  (fs_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_ID;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    case (state)
      S_ID:
        if (accept && bit_cnt == 4'(ID_W - 1)) begin
          if (!id_legal)
            err_nx = 1'b1;
`ifdef RICE_REF_SAMPLE_EN
          else
            state_nx = S_REF;
`else
          else
            state_nx = payload_state(id_full);
`endif
        end
      S_REF:
        if (accept && bit_cnt == 4'(N - 1))
          state_nx = payload_state(id_r);
      S_FS:
        if (fs_ovf) begin
          err_nx   = 1'b1;
          state_nx = S_ID;
        end else if (fs_done && idx == LAST_IDX) begin
          state_nx = (id_r != 4'd0) ? S_SPLIT : S_OUT;
        end
      S_SPLIT:
        if (accept && bit_cnt == k_last && idx == LAST_IDX)
          state_nx = S_OUT;
      S_RAW:
        if (accept && bit_cnt == 4'(N - 1) && idx == LAST_IDX)
          state_nx = S_OUT;
      S_OUT:
        if (out_ready)
          state_nx = S_ID;
      default:
        state_nx = S_ID;
    endcase
  end

  // An illegal ID stays in S_ID but still counts as a fresh entry.
  assign enter = (state_nx != state) || err_nx;

  always_comb begin
    in_ready  = (state != S_OUT);
    out_valid = (state == S_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      idx       <= '0;
      block_err <= 1'b0;
    end else begin
      block_err <= err_nx;
      if (enter) begin
        bit_cnt <= '0;
        idx     <= '0;
      end else if (accept) begin
        case (state)
          S_ID, S_REF: bit_cnt <= bit_cnt + 4'd1;
          S_FS:        if (fs_done) idx <= idx + 5'd1;
          S_SPLIT:
            if (bit_cnt == k_last) begin
              bit_cnt <= '0;
              idx     <= idx + 5'd1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          S_RAW:
            if (bit_cnt == 4'(N - 1)) begin
              bit_cnt <= '0;
              idx     <= idx + 5'd1;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          default: ;
        endcase
      end
    end
  end

  // Split and raw bits shift into the low end of the entry, so the stored m
  // ends up as m << k with the split bits below it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_r <= '0;
      for (int i = 0; i < J; i++)
        fs_mem[i] <= '0;
    end else if (accept) begin
      case (state)
        S_ID:           id_r <= id_full;
        S_FS:           if (fs_done) fs_mem[idx] <= fs_count;
        S_SPLIT, S_RAW: fs_mem[idx] <= {fs_mem[idx][N-2:0], in_bit};
        default: ;
      endcase
    end
  end

`ifdef RICE_REF_SAMPLE_EN
  logic [N-1:0] xref_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      xref_r <= '0;
    else if (accept && state == S_REF)
      xref_r <= {xref_r[N-2:0], in_bit};
  end

  assign xref = xref_r;
`else
  assign xref = '0;
`endif

  always_comb begin
    symbol = '0;
    for (int i = 0; i < J; i++)
      symbol[(J-1-i)*N +: N] = fs_mem[i];
  end

endmodule

// File: tb/tb_rice_block_decoder.sv
// Directed bench for rice_block_decoder: k-option, raw, illegal ID, overflow,
// backpressure and mid-block reset scenarios.
module tb_rice_block_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_bit;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] symbol;
  logic [9:0]   xref;
  logic         out_valid;
  logic         out_ready;
  logic         block_err;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  localparam logic [9:0] REF_VAL = 10'h2A5;
`ifdef RICE_REF_SAMPLE_EN
  localparam logic [9:0] XREF_EXP = 10'h2A5;
`else
  localparam logic [9:0] XREF_EXP = 10'h000;
`endif

  rice_block_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .symbol    (symbol),
    .xref      (xref),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .block_err (block_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (block_err === 1'b1) err_cnt++;

  task automatic send_bit(input logic b);
    in_bit   = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_field(input logic [9:0] v, input int w);
    for (int b = w - 1; b >= 0; b--)
      send_bit(v[b]);
  endtask

  task automatic send_hdr(input logic [3:0] id);
    send_field({6'd0, id}, 4);
`ifdef RICE_REF_SAMPLE_EN
    send_field(REF_VAL, 10);
`endif
  endtask

  task automatic do_handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic send_k2_block();
    send_hdr(4'd2);
    for (int i = 0; i < 32; i++) send_field(10'b01, 2);
    for (int i = 0; i < 31; i++) send_field(10'b01, 2);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL k2_early out_valid=%b expected=0", out_valid);
    end
    send_field(10'b01, 2);
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (block_err !== 1'b0) begin failures++; $display("FAIL reset_block_err got=%b exp=0", block_err); end
    checks++;
    if (symbol !== 320'd0) begin failures++; $display("FAIL reset_symbol got=%h exp=0", symbol); end
    checks++;
    if (xref !== 10'd0) begin failures++; $display("FAIL reset_xref got=%h exp=0", xref); end
  endtask

  task automatic test_k0();
    int e0;
    e0 = err_cnt;
    send_hdr(4'd0);
    for (int i = 0; i < 31; i++) send_bit(1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL k0_early out_valid=%b exp=0", out_valid); end
    send_bit(1'b1);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL k0_valid got=%b exp=1", out_valid); end
    checks++;
    if (symbol !== 320'd0) begin failures++; $display("FAIL k0_symbol got=%h exp=0", symbol); end
    checks++;
    if (xref !== XREF_EXP) begin failures++; $display("FAIL k0_xref got=%h exp=%h", xref, XREF_EXP); end
    checks++;
    if (err_cnt !== e0) begin failures++; $display("FAIL k0_no_err got=%0d exp=%0d", err_cnt, e0); end
    do_handshake();
  endtask

  task automatic test_k2();
    send_k2_block();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL k2_valid got=%b exp=1", out_valid); end
    checks++;
    if (symbol !== {32{10'd5}}) begin failures++; $display("FAIL k2_symbol got=%h exp=%h", symbol, {32{10'd5}}); end
    do_handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL k2_handshake out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_raw_hold();
    logic [319:0] exp_sym;
    int bad;
    exp_sym = '0;
    for (int i = 0; i < 32; i++) exp_sym[(31-i)*10 +: 10] = 10'(i);
    send_hdr(4'hF);
    for (int i = 0; i < 32; i++) send_field(10'(i), 10);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL raw_valid got=%b exp=1", out_valid); end
    checks++;
    if (symbol !== exp_sym) begin failures++; $display("FAIL raw_symbol got=%h exp=%h", symbol, exp_sym); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      @(posedge clk);
      #1;
      if (symbol !== exp_sym || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
    do_handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_handshake out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_illegal();
    send_field(10'b1010, 4);
    checks++;
    if (block_err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", block_err); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL illegal_no_valid got=%b exp=0", out_valid); end
    @(posedge clk);
    #1;
    checks++;
    if (block_err !== 1'b0) begin failures++; $display("FAIL illegal_pulse got=%b exp=0", block_err); end
    send_hdr(4'd0);
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    checks++;
    if (out_valid !== 1'b1 || symbol !== 320'd0) begin
      failures++;
      $display("FAIL illegal_recover out_valid=%b symbol=%h exp 1/0", out_valid, symbol);
    end
    do_handshake();
  endtask

  task automatic test_overflow();
    logic [319:0] exp_sym;
    send_hdr(4'd8);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    checks++;
    if (block_err !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", block_err); end
    send_bit(1'b0);
    checks++;
    if (block_err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%b exp=1", block_err); end
    @(posedge clk);
    #1;
    checks++;
    if (block_err !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_pulse block_err=%b out_valid=%b exp 0/0", block_err, out_valid);
    end
    // k=1 block with m = i%4 and split bit = i%2
    exp_sym = '0;
    for (int i = 0; i < 32; i++) exp_sym[(31-i)*10 +: 10] = 10'(((i % 4) << 1) | (i % 2));
    send_hdr(4'd1);
    for (int i = 0; i < 32; i++) begin
      for (int z = 0; z < (i % 4); z++) send_bit(1'b0);
      send_bit(1'b1);
    end
    for (int i = 0; i < 32; i++) send_bit(1'(i % 2));
    checks++;
    if (out_valid !== 1'b1 || symbol !== exp_sym) begin
      failures++;
      $display("FAIL k1_symbol out_valid=%b got=%h exp=%h", out_valid, symbol, exp_sym);
    end
    do_handshake();
  endtask

  task automatic test_reset_mid();
    send_hdr(4'd2);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || block_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctrl in_ready=%b out_valid=%b block_err=%b exp 1/0/0", in_ready, out_valid, block_err);
    end
    checks++;
    if (symbol !== 320'd0 || xref !== 10'd0) begin
      failures++;
      $display("FAIL midreset_data symbol=%h xref=%h exp 0/0", symbol, xref);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_k2_block();
    checks++;
    if (out_valid !== 1'b1 || symbol !== {32{10'd5}} || xref !== XREF_EXP) begin
      failures++;
      $display("FAIL midreset_recover out_valid=%b symbol=%h xref=%h", out_valid, symbol, xref);
    end
    do_handshake();
  endtask

  initial begin
    reset     = 1'b1;
    in_bit    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_k0();
    test_k2();
    test_raw_hold();
    test_illegal();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
